// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial word adder.
package serial_adder_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell: sum and carry of two inputs.
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_word_adder_fa.sv
// Combinational full adder built from two half_adder cells and an OR for the carry.
module full_adder_bit (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic s1, c1, c2;

   half_adder u_ha1 (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (s1),
      .c_o (c1)
   );

   half_adder u_ha2 (
      .a_i (s1),
      .b_i (c_i),
      .s_o (s_o),
      .c_o (c2)
   );

   assign c_o = c1 | c2;

endmodule

// File: rtl/serial_word_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
module serial_word_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   // One extra counter bit so WIDTH=1 and powers of two still reach WIDTH-1.
   localparam int unsigned   CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sha_q, shb_q, acc_q, s_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, busy_q, done_q;
   logic             fa_s, fa_c;
   logic [WIDTH-1:0] acc_d;

   full_adder_bit u_fa (
      .a_i (sha_q[0]),
      .b_i (shb_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // Sum bit enters at the MSB; after WIDTH shifts the LSB-first bits line up.
   assign acc_d = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  sha_q   <= A;
                  shb_q   <= B;
                  carry_q <= Cin;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sha_q   <= sha_q >> 1;
               shb_q   <= shb_q >> 1;
               acc_q   <= acc_d;
               carry_q <= fa_c;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  s_q     <= acc_d;
                  cout_q  <= fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed and random checks of serial_word_adder at WIDTH = 1, 8 and 32.
module tb_serial_word_adder;

   logic clk = 1'b0;
   logic rst_n;

   logic        st1, a1, b1, c1, bz1, dn1, s1, co1;
   logic        st8, c8, bz8, dn8, co8;
   logic [7:0]  a8, b8, s8;
   logic        st32, c32, bz32, dn32, co32;
   logic [31:0] a32, b32, s32;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

   always #5 clk = ~clk;

   serial_word_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .Cin(c1),
      .busy(bz1), .done(dn1), .S(s1), .Cout(co1)
   );

   serial_word_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .Cin(c8),
      .busy(bz8), .done(dn8), .S(s8), .Cout(co8)
   );

   serial_word_adder #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .start(st32), .A(a32), .B(b32), .Cin(c32),
      .busy(bz32), .done(dn32), .S(s32), .Cout(co32)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       cout;
      string      name;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One WIDTH=8 addition; operands are scrambled during RUN to prove they are not re-sampled.
   task automatic op8(input vec_t v);
      int unsigned nbusy, lat;
      logic [7:0]  rs;
      logic        rc;
      nbusy = 0; lat = 0; rs = '0; rc = 1'b0;
      @(negedge clk);
      a8 = v.a; b8 = v.b; c8 = v.cin; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; a8 = ~v.a; b8 = ~v.b; c8 = ~v.cin;
      for (int unsigned i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         if (bz8) nbusy++;
         if (dn8) begin
            lat = i; rs = s8; rc = co8;
            break;
         end
      end
      chk({v.name, "_latency"}, 64'(lat), 64'd9);
      chk({v.name, "_busy_cycles"}, 64'(nbusy), 64'd8);
      chk({v.name, "_S"}, 64'(rs), 64'(v.s));
      chk({v.name, "_Cout"}, 64'(rc), 64'(v.cout));
      @(negedge clk);
      chk({v.name, "_done_one_cycle"}, 64'(dn8), 64'd0);
      chk({v.name, "_S_hold"}, 64'(s8), 64'(v.s));
   endtask

   initial begin
      vec_t vecs[8];
      int unsigned ndone, lat1, lat2;
      logic [7:0]  rs;
      logic        rc;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero"};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1"};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5_5a_cin"};
      vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c_0f"};
      vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, "80_7f_cin"};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "12_34"};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_ff_cin"};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "7f_01"};

      rst_n = 1'b0;
      st1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      st8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;
      st32 = 1'b0; a32 = '0; b32 = '0;  c32 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy8", 64'(bz8), 64'd0);
      chk("rst_done8", 64'(dn8), 64'd0);
      chk("rst_S8", 64'(s8), 64'd0);
      chk("rst_Cout8", 64'(co8), 64'd0);
      chk("rst_busy1", 64'(bz1), 64'd0);
      chk("rst_S32", 64'(s32), 64'd0);
      rst_n = 1'b1;

      for (int unsigned i = 0; i < 8; i++) op8(vecs[i]);

      // start pulsed mid-RUN is ignored: exactly one done with the original sum
      @(negedge clk);
      a8 = 8'h22; b8 = 8'h33; c8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      ndone = 0; rs = '0; rc = 1'b1;
      for (int unsigned i = 1; i <= 25; i++) begin
         if (i > 1) @(negedge clk);
         if (dn8) begin ndone++; rs = s8; rc = co8; end
         if (i == 4) begin a8 = 8'h11; st8 = 1'b1; end
         if (i == 5) st8 = 1'b0;
      end
      chk("ignore_start_ndone", 64'(ndone), 64'd1);
      chk("ignore_start_S", 64'(rs), 64'h55);
      chk("ignore_start_Cout", 64'(rc), 64'd0);
      chk("ignore_start_idle", 64'(bz8), 64'd0);

      // start held through DONE chains a second addition immediately
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h02;
      lat1 = 0; lat2 = 0;
      for (int unsigned i = 1; i <= 40; i++) begin
         if (i > 1) @(negedge clk);
         if (dn8) begin
            if (lat1 == 0) begin
               lat1 = i;
               chk("b2b_first_S", 64'(s8), 64'h00);
               chk("b2b_first_Cout", 64'(co8), 64'd1);
            end else if (lat2 == 0) begin
               lat2 = i;
               chk("b2b_second_S", 64'(s8), 64'h03);
               chk("b2b_second_Cout", 64'(co8), 64'd0);
            end
         end
         if (i == 10) begin
            chk("b2b_busy_reassert", 64'(bz8), 64'd1);
            st8 = 1'b0;
         end
      end
      chk("b2b_first_latency", 64'(lat1), 64'd9);
      chk("b2b_second_latency", 64'(lat2), 64'd18);

      // reset during RUN aborts with no done and cleared result
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 64'(bz8), 64'd0);
      chk("abort_done", 64'(dn8), 64'd0);
      chk("abort_S", 64'(s8), 64'd0);
      chk("abort_Cout", 64'(co8), 64'd0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (dn8) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);

      // random operands at all three widths, launched together
      for (int unsigned v = 0; v < 1000; v++) begin
         logic [31:0] ra, rb;
         logic        rcin;
         logic [1:0]  e1;
         logic [8:0]  e8;
         logic [32:0] e32;
         int unsigned l1, l8, l32;
         ra = $urandom; rb = $urandom; rcin = 1'($urandom_range(1));
         e1  = {1'b0, ra[0]} + {1'b0, rb[0]} + {1'b0, rcin};
         e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, rcin};
         e32 = {1'b0, ra} + {1'b0, rb} + {32'd0, rcin};
         l1 = 0; l8 = 0; l32 = 0;
         @(negedge clk);
         a1 = ra[0]; b1 = rb[0]; c1 = rcin; st1 = 1'b1;
         a8 = ra[7:0]; b8 = rb[7:0]; c8 = rcin; st8 = 1'b1;
         a32 = ra; b32 = rb; c32 = rcin; st32 = 1'b1;
         @(negedge clk);
         st1 = 1'b0; st8 = 1'b0; st32 = 1'b0;
         for (int unsigned i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (dn1 && l1 == 0) begin
               l1 = i;
               chk("rnd_w1_sum", 64'({co1, s1}), 64'(e1));
            end
            if (dn8 && l8 == 0) begin
               l8 = i;
               chk("rnd_w8_sum", 64'({co8, s8}), 64'(e8));
            end
            if (dn32 && l32 == 0) begin
               l32 = i;
               chk("rnd_w32_sum", 64'({co32, s32}), 64'(e32));
            end
            if (l1 != 0 && l8 != 0 && l32 != 0) break;
         end
         chk("rnd_w1_latency", 64'(l1), 64'd2);
         chk("rnd_w8_latency", 64'(l8), 64'd9);
         chk("rnd_w32_latency", 64'(l32), 64'd33);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
